key_entry: RTL and testbench

- Downstream consumer of the 4x4 matrix keypad scanner.
- Turns a stream of decoded key codes into a calculator-style multi-digit decimal entry, and drives the live BCD buffer to the display.
- On ENTER, converts the buffer sequentially to binary and publishes it as the committed setpoint used by the water-level comparison logic.

---
 rtl/key_pkg.sv | 19 +
 rtl/bcd_to_bin_seq.sv | 81 ++++++++
 rtl/key_entry.sv | 193 +++++++++++++++++++
 tb/tb_key_entry.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad entry path: key codes, FSM encoding and key classifiers.
package key_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   typedef enum logic [1:0] {IDLE, EDIT, CONVERT, DONE} state_e;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   // Codes D-F carry no meaning anywhere in the entry flow.
   function automatic logic is_active(input logic [3:0] k);
      return k <= KEY_CLR;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, most significant first.
// A start pulse loads the accumulator; done_o pulses once the last digit has been folded in.
module bcd_to_bin_seq
   import key_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned VAL_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [4*DIGITS-1:0]   bcd_i,
   output logic [VAL_W+3:0]      acc_o,
   output logic                  ovf_o,
   output logic                  done_o
);

   localparam int unsigned AW = VAL_W + 4;
   localparam int unsigned WW = AW + 4;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [AW-1:0] acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          run_q, run_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic [3:0]    digit;
   logic [WW-1:0] mac;

   // Multiply-accumulate step; the widened result exposes wrap of the accumulator.
   always_comb begin
      digit = bcd_i[{idx_q, 2'b00} +: 4];
      mac   = (WW'(acc_q) << 3) + (WW'(acc_q) << 1) + WW'(digit);
   end

   // Next-state for the digit walk; ovf is sticky across the whole conversion.
   always_comb begin
      acc_d  = acc_q;
      idx_d  = idx_q;
      run_d  = run_q;
      ovf_d  = ovf_q;
      done_d = 1'b0;
      if (start_i) begin
         acc_d = '0;
         idx_d = IW'(DIGITS - 1);
         run_d = 1'b1;
         ovf_d = 1'b0;
      end else if (run_q) begin
         acc_d = mac[AW-1:0];
         ovf_d = ovf_q | (|mac[WW-1:AW]);
         if (idx_q == '0) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            idx_d = idx_q - IW'(1);
         end
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         idx_q  <= '0;
         run_q  <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         idx_q  <= idx_d;
         run_q  <= run_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

   assign acc_o  = acc_q;
   assign ovf_o  = ovf_q;
   assign done_o = done_q;

endmodule

// File: rtl/key_entry.sv
// Calculator-style decimal entry from keypad codes; commits a binary setpoint on ENTER.
// Optional feature: define KEY_ENTRY_TIMEOUT_EN to abandon an idle open entry after
// TIMEOUT_CYC cycles.
module key_entry
   import key_pkg::*;
#(
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned VAL_W       = 10,
   parameter int unsigned MAX_VAL     = 999,
   parameter int unsigned RESET_VAL   = 0,
   parameter int unsigned TIMEOUT_CYC = 50000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            key,
   input  logic                  key_valid,
   output logic [4*DIGITS-1:0]   disp_bcd,
   output logic [DIGITS-1:0]     disp_blank,
   output logic                  editing,
   output logic                  busy,
   output logic [VAL_W-1:0]      value,
   output logic                  value_valid,
   output logic                  entry_err
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned AW = VAL_W + 4;
   localparam logic [AW-1:0] MaxAcc = AW'(MAX_VAL);

   state_e           state_q, state_d;
   logic [BW-1:0]    buf_q, buf_d;
   logic [CW-1:0]    count_q, count_d;
   logic [VAL_W-1:0] value_q, value_d;
   logic             vv_q, vv_d;
   logic             err_q, err_d;
   logic             key_act, timeout, conv_start, conv_ovf, conv_done, commit_ok;
   logic [AW-1:0]    conv_acc;

   assign key_act   = key_valid && is_active(key);
   assign commit_ok = !conv_ovf && (conv_acc <= MaxAcc);

`ifdef KEY_ENTRY_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;

   assign timeout = (state_q == EDIT) && !key_act && (tmo_q == 32'(TIMEOUT_CYC - 1));

   // Idle counter: runs only in EDIT, restarts on every accepted key.
   always_comb begin
      tmo_d = '0;
      if (state_q == EDIT && !key_act && !timeout) tmo_d = tmo_q + 32'd1;
   end

   // Idle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state; keys are only looked at in IDLE and EDIT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (key_act && is_digit(key)) state_d = EDIT;
         EDIT: begin
            if (timeout) begin
               state_d = IDLE;
            end else if (key_act) begin
               if (key == KEY_CLR)                               state_d = IDLE;
               else if (key == KEY_BKSP && count_q == CW'(1))   state_d = IDLE;
               else if (key == KEY_ENTER)                        state_d = CONVERT;
            end
         end
         CONVERT: if (conv_done) state_d = DONE;
         DONE:    state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      editing = (state_q == EDIT);
      busy    = (state_q == CONVERT) || (state_q == DONE);
   end

   // Buffer, digit count and commit next-state.
   always_comb begin
      buf_d      = buf_q;
      count_d    = count_q;
      value_d    = value_q;
      vv_d       = 1'b0;
      err_d      = 1'b0;
      conv_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_act && is_digit(key)) begin
               buf_d   = BW'(key);
               count_d = CW'(1);
            end
         end
         EDIT: begin
            if (timeout) begin
               buf_d   = '0;
               count_d = '0;
               err_d   = 1'b1;
            end else if (key_act) begin
               if (is_digit(key)) begin
                  if (count_q < CW'(DIGITS)) begin
                     buf_d   = (buf_q << 4) | BW'(key);
                     count_d = count_q + CW'(1);
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (key == KEY_BKSP) begin
                  buf_d   = buf_q >> 4;
                  count_d = count_q - CW'(1);
               end else if (key == KEY_CLR) begin
                  buf_d   = '0;
                  count_d = '0;
               end else begin
                  conv_start = 1'b1;
               end
            end
         end
         CONVERT: begin
            if (conv_done) begin
               if (commit_ok) begin
                  value_d = conv_acc[VAL_W-1:0];
                  vv_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DONE: begin
            buf_d   = '0;
            count_d = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         count_q <= '0;
         value_q <= VAL_W'(RESET_VAL);
         vv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         count_q <= count_d;
         value_q <= value_d;
         vv_q    <= vv_d;
         err_q   <= err_d;
      end
   end

   // Positions at or above the digit count are blank.
   always_comb begin
      disp_blank = '1;
      for (int i = 0; i < int'(DIGITS); i++) disp_blank[i] = (CW'(i) >= count_q);
   end

   bcd_to_bin_seq #(
      .DIGITS (DIGITS),
      .VAL_W  (VAL_W)
   ) u_conv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (conv_start),
      .bcd_i   (buf_q),
      .acc_o   (conv_acc),
      .ovf_o   (conv_ovf),
      .done_o  (conv_done)
   );

   assign disp_bcd    = buf_q;
   assign value       = value_q;
   assign value_valid = vv_q;
   assign entry_err   = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: two instances (MAX_VAL 999 and 500) share stimulus; per-key display
// checks come from a vector table, commit/error pulses from a timed scoreboard.
module tb_key_entry;

   localparam int unsigned DIGITS = 3;
   localparam int unsigned VAL_W  = 10;
   localparam int unsigned MAX_A  = 999;
   localparam int unsigned MAX_B  = 500;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [3:0]       key = 4'h0;
   logic             key_valid = 1'b0;

   logic [11:0]      a_bcd, b_bcd;
   logic [2:0]       a_blank, b_blank;
   logic             a_edit, b_edit, a_busy, b_busy, a_vv, b_vv, a_err, b_err;
   logic [VAL_W-1:0] a_val, b_val;

   key_entry #(.DIGITS(DIGITS), .VAL_W(VAL_W), .MAX_VAL(MAX_A), .RESET_VAL(0),
               .TIMEOUT_CYC(20)) dut_a (
      .clk (clk), .rst_n (rst_n), .key (key), .key_valid (key_valid),
      .disp_bcd (a_bcd), .disp_blank (a_blank), .editing (a_edit), .busy (a_busy),
      .value (a_val), .value_valid (a_vv), .entry_err (a_err)
   );

   key_entry #(.DIGITS(DIGITS), .VAL_W(VAL_W), .MAX_VAL(MAX_B), .RESET_VAL(0),
               .TIMEOUT_CYC(20)) dut_b (
      .clk (clk), .rst_n (rst_n), .key (key), .key_valid (key_valid),
      .disp_bcd (b_bcd), .disp_blank (b_blank), .editing (b_edit), .busy (b_busy),
      .value (b_val), .value_valid (b_vv), .entry_err (b_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  k;
      int unsigned wait_cyc;
      logic        err;
      logic        commit;
      logic [11:0] bcd;
      logic [2:0]  blank;
      logic        editing;
   } vec_t;

   typedef struct {
      int unsigned due;
      logic        a_vv, a_err;
      logic [9:0]  a_val;
      logic        b_vv, b_err;
      logic [9:0]  b_val;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [9:0]  model_a = '0;
   logic [9:0]  model_b = '0;
   vec_t        vecs[23];
   int unsigned c;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned bcd2int(input logic [11:0] b);
      return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
   endfunction

   task automatic push_err(input int unsigned due);
      exp_t e;
      e = '{due, 1'b0, 1'b1, model_a, 1'b0, 1'b1, model_b};
      sb.push_back(e);
   endtask

   // ENTER sampled at the edge after stimulus cycle cc; pulse lands DIGITS+1 edges later.
   task automatic push_commit(input int unsigned cc, input int unsigned v);
      exp_t e;
      e.due = cc + DIGITS + 2;
      if (v <= MAX_A) begin model_a = 10'(v); e.a_vv = 1'b1; e.a_err = 1'b0; end
      else            begin e.a_vv = 1'b0; e.a_err = 1'b1; end
      if (v <= MAX_B) begin model_b = 10'(v); e.b_vv = 1'b1; e.b_err = 1'b0; end
      else            begin e.b_vv = 1'b0; e.b_err = 1'b1; end
      e.a_val = model_a;
      e.b_val = model_b;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every pulse must be expected at exactly its due cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("a_value_valid", 32'(a_vv), 32'(sb[0].a_vv));
            chk("a_entry_err", 32'(a_err), 32'(sb[0].a_err));
            chk("a_value", 32'(a_val), 32'(sb[0].a_val));
            chk("b_value_valid", 32'(b_vv), 32'(sb[0].b_vv));
            chk("b_entry_err", 32'(b_err), 32'(sb[0].b_err));
            chk("b_value", 32'(b_val), 32'(sb[0].b_val));
            void'(sb.pop_front());
         end else if (a_vv || a_err || b_vv || b_err) begin
            chk("unexpected_pulse", {28'd0, a_vv, a_err, b_vv, b_err}, 32'd0);
         end
      end
   end

   task automatic press(input logic [3:0] k, output int unsigned cc);
      @(negedge clk);
      key = k;
      key_valid = 1'b1;
      cc = cyc;
   endtask

   task automatic release_key();
      @(negedge clk);
      key_valid = 1'b0;
      key = 4'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'h1, 0, 1'b0, 1'b0, 12'h001, 3'b110, 1'b1};
      vecs[1]  = '{4'hE, 0, 1'b0, 1'b0, 12'h001, 3'b110, 1'b1};
      vecs[2]  = '{4'h2, 0, 1'b0, 1'b0, 12'h012, 3'b100, 1'b1};
      vecs[3]  = '{4'h3, 0, 1'b0, 1'b0, 12'h123, 3'b000, 1'b1};
      vecs[4]  = '{4'hA, 6, 1'b0, 1'b1, 12'h123, 3'b000, 1'b0};
      vecs[5]  = '{4'h7, 0, 1'b0, 1'b0, 12'h007, 3'b110, 1'b1};
      vecs[6]  = '{4'hB, 0, 1'b0, 1'b0, 12'h000, 3'b111, 1'b0};
      vecs[7]  = '{4'h4, 0, 1'b0, 1'b0, 12'h004, 3'b110, 1'b1};
      vecs[8]  = '{4'hA, 6, 1'b0, 1'b1, 12'h004, 3'b110, 1'b0};
      vecs[9]  = '{4'h9, 0, 1'b0, 1'b0, 12'h009, 3'b110, 1'b1};
      vecs[10] = '{4'h9, 0, 1'b0, 1'b0, 12'h099, 3'b100, 1'b1};
      vecs[11] = '{4'h9, 0, 1'b0, 1'b0, 12'h999, 3'b000, 1'b1};
      vecs[12] = '{4'h9, 0, 1'b1, 1'b0, 12'h999, 3'b000, 1'b1};
      vecs[13] = '{4'hA, 6, 1'b0, 1'b1, 12'h999, 3'b000, 1'b0};
      vecs[14] = '{4'h6, 0, 1'b0, 1'b0, 12'h006, 3'b110, 1'b1};
      vecs[15] = '{4'h0, 0, 1'b0, 1'b0, 12'h060, 3'b100, 1'b1};
      vecs[16] = '{4'h0, 0, 1'b0, 1'b0, 12'h600, 3'b000, 1'b1};
      vecs[17] = '{4'hA, 6, 1'b0, 1'b1, 12'h600, 3'b000, 1'b0};
      vecs[18] = '{4'h5, 0, 1'b0, 1'b0, 12'h005, 3'b110, 1'b1};
      vecs[19] = '{4'hC, 0, 1'b0, 1'b0, 12'h000, 3'b111, 1'b0};
      vecs[20] = '{4'hA, 2, 1'b0, 1'b0, 12'h000, 3'b111, 1'b0};
      vecs[21] = '{4'hD, 0, 1'b0, 1'b0, 12'h000, 3'b111, 1'b0};
      vecs[22] = '{4'hB, 0, 1'b0, 1'b0, 12'h000, 3'b111, 1'b0};

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_value", 32'(a_val), 32'd0);
      chk("reset_bcd", 32'(a_bcd), 32'd0);
      chk("reset_blank", 32'(a_blank), 32'b111);
      chk("reset_editing", 32'(a_edit), 32'd0);
      chk("reset_busy", 32'(a_busy), 32'd0);
      chk("reset_pulses", {30'd0, a_vv, a_err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         press(vecs[i].k, c);
         if (vecs[i].err)    push_err(c + 1);
         if (vecs[i].commit) push_commit(c, bcd2int(vecs[i].bcd));
         release_key();
         chk($sformatf("vec%0d_bcd", i), 32'(a_bcd), 32'(vecs[i].bcd));
         chk($sformatf("vec%0d_blank", i), 32'(a_blank), 32'(vecs[i].blank));
         chk($sformatf("vec%0d_editing", i), 32'(a_edit), 32'(vecs[i].editing));
         repeat (vecs[i].wait_cyc) @(negedge clk);
      end

      // A key strobed during CONVERT is dropped.
      press(4'h2, c);
      release_key();
      chk("cv_bcd_entry", 32'(a_bcd), 32'h002);
      press(4'hA, c);
      push_commit(c, 2);
      release_key();
      press(4'h8, c);
      chk("cv_busy", 32'(a_busy), 32'd1);
      release_key();
      chk("cv_bcd_hold", 32'(a_bcd), 32'h002);
      repeat (4) @(negedge clk);
      chk("cv_bcd_after", 32'(a_bcd), 32'h000);
      chk("cv_blank_after", 32'(a_blank), 32'b111);
      chk("cv_idle", {30'd0, a_edit, a_busy}, 32'd0);

      // Reset in the middle of a conversion.
      press(4'h7, c);
      release_key();
      press(4'hA, c);
      release_key();
      @(negedge clk);
      chk("rc_busy", 32'(a_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rc_value_a", 32'(a_val), 32'd0);
      chk("rc_value_b", 32'(b_val), 32'd0);
      chk("rc_busy_after", 32'(a_busy), 32'd0);
      chk("rc_blank", 32'(a_blank), 32'b111);
      model_a = '0;
      model_b = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Normal commit after the reset.
      press(4'h4, c);
      release_key();
      press(4'h2, c);
      release_key();
      press(4'hA, c);
      push_commit(c, 42);
      release_key();
      repeat (6) @(negedge clk);

`ifdef KEY_ENTRY_TIMEOUT_EN
      press(4'h3, c);
      push_err(c + 21);
      release_key();
      chk("to_editing", 32'(a_edit), 32'd1);
      repeat (21) @(negedge clk);
      chk("to_idle", 32'(a_edit), 32'd0);
      chk("to_bcd", 32'(a_bcd), 32'h000);
      chk("to_value", 32'(a_val), 32'd42);
`endif

      for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
